// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler sharing one 3x3 combinational multiplier among NUM_REQ requesters.
// Optional per-requester grant counters are built when MULT_RR_STATS_EN is defined.

module multiplier (
    input  logic [2:0] A,
    input  logic [2:0] B,
    output logic [5:0] P
);
    assign P = {3'b000, A} * {3'b000, B};
endmodule

module mult_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [3*NUM_REQ-1:0]   req_a,
    input  logic [3*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [5:0]             res_p,
    output logic [ID_W-1:0]        res_id,
    output logic                   busy
`ifdef MULT_RR_STATS_EN
   ,output logic [CNT_W*NUM_REQ-1:0] grant_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

    state_t          state, state_nxt;
    logic [ID_W-1:0] rr_ptr, grant, scan_idx, id_q;
    logic            found, accept;
    logic [2:0]      sel_a, sel_b, op_a, op_b;
    logic [5:0]      mult_p;

    // Search starts at rr_ptr so the last winner drops to lowest priority.
    always_comb begin
        // NOTE: every combinational output gets a default first, otherwise a latch is inferred.
        found    = 1'b0;
        grant    = '0;
        scan_idx = '0;
        sel_a    = '0;
        sel_b    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!found && req_valid[scan_idx]) begin
                found = 1'b1;
                grant = scan_idx;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == ID_W'(i)) begin
                sel_a = req_a[3*i +: 3];
                sel_b = req_b[3*i +: 3];
            end
        end
    end

    assign accept    = (state == IDLE) && found;
    assign req_ready = (!reset && accept) ? (NUM_REQ'(1) << grant) : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = CALC;
            CALC:    state_nxt = OUT;
            OUT:     if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    multiplier u_mult (op_a, op_b, mult_p);

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            id_q      <= '0;
            res_valid <= 1'b0;
            res_p     <= '0;
            res_id    <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    op_a   <= sel_a;
                    op_b   <= sel_b;
                    id_q   <= grant;
                    rr_ptr <= (grant == ID_W'(NUM_REQ-1)) ? '0 : grant + 1'b1;
                end
                CALC: begin
                    res_p     <= mult_p;
                    res_id    <= id_q;
                    res_valid <= 1'b1;
                end
                OUT: if (res_ready) res_valid <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef MULT_RR_STATS_EN
    logic [CNT_W-1:0] cnt_q [NUM_REQ];

    // Saturating counters: stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (reset)
                cnt_q[i] <= '0;
            else if (accept && grant == ID_W'(i) && cnt_q[i] != '1)
                cnt_q[i] <= cnt_q[i] + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
        assign grant_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Directed bench for mult_rr_scheduler: table of single transactions plus multi-cycle
// sequences for fairness, backpressure, mid-operation reset and (optionally) grant counters.

module tb_mult_rr_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [11:0] req_a, req_b;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic        res_ready;
    logic [5:0]  res_p;
    logic [1:0]  res_id;
    logic        busy;
`ifdef MULT_RR_STATS_EN
    logic [31:0] grant_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mult_rr_scheduler #(.NUM_REQ(4), .ID_W(2), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_p     (res_p),
        .res_id    (res_id),
        .busy      (busy)
`ifdef MULT_RR_STATS_EN
       ,.grant_cnt (grant_cnt)
`endif
    );

    typedef struct {
        logic [3:0]  valid;
        logic [11:0] a;
        logic [11:0] b;
        logic [3:0]  exp_ready;
        logic [1:0]  exp_id;
        logic [5:0]  exp_p;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // One full transaction with res_ready high; starts and ends with the block idle.
    task automatic run_txn(input string name, input logic [3:0] valid, input logic [11:0] a,
                           input logic [11:0] b, input logic [3:0] exp_ready,
                           input logic [1:0] exp_id, input logic [5:0] exp_p);
        @(posedge clk); #1;
        req_valid = valid;
        req_a     = a;
        req_b     = b;
        res_ready = 1'b1;
        @(negedge clk);
        check({name, " req_ready"}, 32'(req_ready), 32'(exp_ready));
        check({name, " busy idle"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check({name, " busy calc"}, 32'(busy), 32'd1);
        check({name, " no early valid"}, 32'(res_valid), 32'd0);
        @(negedge clk);
        check({name, " res_valid"}, 32'(res_valid), 32'd1);
        check({name, " res_p"}, 32'(res_p), 32'(exp_p));
        check({name, " res_id"}, 32'(res_id), 32'(exp_id));
        @(negedge clk);
        check({name, " busy after hs"}, 32'(busy), 32'd0);
        check({name, " valid after hs"}, 32'(res_valid), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b0;

        // Operand packing is {req3, req2, req1, req0}.
        vecs[0] = '{4'b0001, {3'd0,3'd0,3'd0,3'd5}, {3'd0,3'd0,3'd0,3'd7}, 4'b0001, 2'd0, 6'd35};
        vecs[1] = '{4'b0100, {3'd0,3'd6,3'd0,3'd0}, {3'd0,3'd6,3'd0,3'd0}, 4'b0100, 2'd2, 6'd36};
        vecs[2] = '{4'b1111, {3'd0,3'd7,3'd2,3'd1}, {3'd5,3'd7,3'd3,3'd1}, 4'b1000, 2'd3, 6'd0};
        vecs[3] = '{4'b1111, {3'd0,3'd7,3'd2,3'd1}, {3'd5,3'd7,3'd3,3'd1}, 4'b0001, 2'd0, 6'd1};
        vecs[4] = '{4'b1111, {3'd0,3'd7,3'd2,3'd1}, {3'd5,3'd7,3'd3,3'd1}, 4'b0010, 2'd1, 6'd6};
        vecs[5] = '{4'b1111, {3'd0,3'd7,3'd2,3'd1}, {3'd5,3'd7,3'd3,3'd1}, 4'b0100, 2'd2, 6'd49};
        vecs[6] = '{4'b0011, {3'd0,3'd0,3'd4,3'd3}, {3'd0,3'd0,3'd5,3'd2}, 4'b0001, 2'd0, 6'd6};
        vecs[7] = '{4'b1001, {3'd7,3'd0,3'd0,3'd1}, {3'd6,3'd0,3'd0,3'd1}, 4'b1000, 2'd3, 6'd42};
        vecs[8] = '{4'b0110, {3'd0,3'd4,3'd7,3'd0}, {3'd0,3'd7,3'd7,3'd0}, 4'b0010, 2'd1, 6'd49};

        do_reset();
        @(negedge clk);
        check("reset res_valid", 32'(res_valid), 32'd0);
        check("reset res_p", 32'(res_p), 32'd0);
        check("reset res_id", 32'(res_id), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset req_ready", 32'(req_ready), 32'd0);

        // Table: rr_ptr evolves 0 -> 1 -> 3 -> 0 -> 1 -> 2 -> 3 -> 1 -> 0 -> 2.
        for (int i = 0; i < 9; i++)
            run_txn($sformatf("vec%0d", i), vecs[i].valid, vecs[i].a, vecs[i].b,
                    vecs[i].exp_ready, vecs[i].exp_id, vecs[i].exp_p);

        // Fairness: all valid from reset, accepts every 3 cycles, ids 0,1,2,3,0.
        begin
            logic [1:0] exp_ids [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
            logic [5:0] exp_ps  [5] = '{6'd1, 6'd6, 6'd49, 6'd0, 6'd1};
            int n_res = 0, n_acc = 0, last_acc = -1;
            do_reset();
            req_valid = 4'b1111;
            req_a     = {3'd0,3'd7,3'd2,3'd1};
            req_b     = {3'd5,3'd7,3'd3,3'd1};
            res_ready = 1'b1;
            for (int cyc = 0; cyc < 15; cyc++) begin
                @(negedge clk);
                if (req_ready != 4'b0000) begin
                    if (last_acc >= 0) check("rr accept spacing", 32'(cyc - last_acc), 32'd3);
                    last_acc = cyc;
                    n_acc++;
                end
                if (res_valid && n_res < 5) begin
                    check($sformatf("rr res_id %0d", n_res), 32'(res_id), 32'(exp_ids[n_res]));
                    check($sformatf("rr res_p %0d", n_res), 32'(res_p), 32'(exp_ps[n_res]));
                    n_res++;
                end
            end
            check("rr result count", 32'(n_res), 32'd5);
            check("rr accept count", 32'(n_acc), 32'd5);
        end

        // Backpressure: result held for 5 cycles while other requesters wait.
        do_reset();
        req_valid = 4'b0001;
        req_a     = {3'd0,3'd0,3'd0,3'd3};
        req_b     = {3'd0,3'd0,3'd0,3'd5};
        res_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 4'b1110;
        @(negedge clk);
        check("bp busy calc", 32'(busy), 32'd1);
        @(negedge clk);
        check("bp res_valid", 32'(res_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp hold valid %0d", i), 32'(res_valid), 32'd1);
            check($sformatf("bp hold p %0d", i), 32'(res_p), 32'd15);
            check($sformatf("bp hold id %0d", i), 32'(res_id), 32'd0);
            check($sformatf("bp hold ready %0d", i), 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(negedge clk);
        check("bp before hs", 32'(res_valid), 32'd1);
        @(negedge clk);
        check("bp idle busy", 32'(busy), 32'd0);
        check("bp idle valid", 32'(res_valid), 32'd0);
        check("bp next grant", 32'(req_ready), 32'b0010);

        // Reset during CALC of 6*6 from requester 2: result discarded, rr_ptr back to 0.
        do_reset();
        req_valid = 4'b0100;
        req_a     = {3'd0,3'd6,3'd0,3'd1};
        req_b     = {3'd0,3'd6,3'd0,3'd1};
        res_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 4'b1111;
        reset     = 1'b1;
        @(negedge clk);
        check("mid-reset req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post-reset busy", 32'(busy), 32'd0);
        check("post-reset valid", 32'(res_valid), 32'd0);
        check("post-reset grant", 32'(req_ready), 32'b0001);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        @(negedge clk);
        check("post-reset no stale", 32'(res_valid), 32'd0);
        @(negedge clk);
        check("post-reset res_valid", 32'(res_valid), 32'd1);
        check("post-reset res_id", 32'(res_id), 32'd0);
        check("post-reset res_p", 32'(res_p), 32'd1);

`ifdef MULT_RR_STATS_EN
        do_reset();
        for (int i = 0; i < 300; i++)
            run_txn("stats r1", 4'b0010, {3'd0,3'd0,3'd1,3'd0}, {3'd0,3'd0,3'd1,3'd0},
                    4'b0010, 2'd1, 6'd1);
        for (int i = 0; i < 2; i++)
            run_txn("stats r3", 4'b1000, {3'd2,3'd0,3'd0,3'd0}, {3'd3,3'd0,3'd0,3'd0},
                    4'b1000, 2'd3, 6'd6);
        @(negedge clk);
        check("cnt0", 32'(grant_cnt[7:0]), 32'd0);
        check("cnt1 saturated", 32'(grant_cnt[15:8]), 32'd255);
        check("cnt2", 32'(grant_cnt[23:16]), 32'd0);
        check("cnt3", 32'(grant_cnt[31:24]), 32'd2);
        do_reset();
        @(negedge clk);
        check("cnt cleared", grant_cnt, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
